// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, memory and fetch stalls,
// discard of a stale fetch after a taken branch, and stall/timeout bookkeeping.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module hazard_ctrl (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [`RF_ADDR_WIDTH-1:0] idRs1,
  input  logic [`RF_ADDR_WIDTH-1:0] idRs2,
  input  logic                      idUsesRs1,
  input  logic                      idUsesRs2,
  input  logic                      idexMemRead,
  input  logic [`RF_ADDR_WIDTH-1:0] idexRd,
  input  logic                      exBranchTaken,
  input  logic                      memReq,
  input  logic                      memReady,
  input  logic                      ifReady,
  input  logic                      clrCount,
  output logic                      pcWrite,
  output logic                      ifidWrite,
  output logic                      ifidFlush,
  output logic                      idexWrite,
  output logic                      idexFlush,
  output logic                      exmemWrite,
  output logic                      memwbWrite,
  output logic [1:0]                state,
  output logic [15:0]               stallCount,
  output logic                      memTimeout
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    DISCARD = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_wait_cnt_q, mem_wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        mem_stall_s;
  logic        load_use_s;

  assign mem_stall_s = memReq && !memReady;
  assign load_use_s  = idexMemRead && (idexRd != {`RF_ADDR_WIDTH{1'b0}}) &&
                       ((idUsesRs1 && (idRs1 == idexRd)) ||
                        (idUsesRs2 && (idRs2 == idexRd)));

  // Pipeline enables/flushes: priority chain, combinational from state and inputs.
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexWrite  = 1'b1;
    idexFlush  = 1'b0;
    exmemWrite = 1'b1;
    memwbWrite = 1'b1;
    if (mem_stall_s) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
      memwbWrite = 1'b0;
    end else if (state_q == DISCARD) begin
      pcWrite   = 1'b0;
      ifidFlush = 1'b1;
    end else if (exBranchTaken) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (load_use_s) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      idexFlush = 1'b1;
    end else if (!ifReady) begin
      pcWrite   = 1'b0;
      ifidFlush = 1'b1;
    end else begin
      pcWrite = 1'b1;
    end
  end

  // Next state; DISCARD drops the fetch that was in flight when the branch resolved.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_stall_s) begin
          state_d = MEMWAIT;
        end else if (exBranchTaken && !ifReady) begin
          state_d = DISCARD;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (memReady) begin
          state_d = RUN;
        end else begin
          state_d = MEMWAIT;
        end
      end
      DISCARD: begin
        if (ifReady) begin
          state_d = RUN;
        end else begin
          state_d = DISCARD;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Counter next values: memory wait length, sticky timeout, saturating stall count.
  always_comb begin
    mem_wait_cnt_d = 8'd0;
    if (mem_stall_s) begin
      if (mem_wait_cnt_q != 8'hFF) begin
        mem_wait_cnt_d = mem_wait_cnt_q + 8'd1;
      end else begin
        mem_wait_cnt_d = mem_wait_cnt_q;
      end
    end else begin
      mem_wait_cnt_d = 8'd0;
    end
    mem_timeout_d = mem_timeout_q || (mem_wait_cnt_d == 8'hFF);
    stall_count_d = stall_count_q;
    if (clrCount) begin
      stall_count_d = 16'd0;
    end else if (!pcWrite && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      mem_wait_cnt_q <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      mem_wait_cnt_q <= mem_wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign state      = state_q;
  assign stallCount = stall_count_q;
  assign memTimeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a priority-table reference model.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module tb_hazard_ctrl;
  localparam int AW = `RF_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] idRs1, idRs2, idexRd;
  logic idUsesRs1, idUsesRs2, idexMemRead, exBranchTaken;
  logic memReq, memReady, ifReady, clrCount;
  logic pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbWrite;
  logic [1:0] state;
  logic [15:0] stallCount;
  logic memTimeout;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0=RUN 1=MEMWAIT 2=DISCARD
  int m_state, m_stall, m_wait;
  bit m_to;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idexMemRead(idexMemRead), .idexRd(idexRd), .exBranchTaken(exBranchTaken),
    .memReq(memReq), .memReady(memReady), .ifReady(ifReady), .clrCount(clrCount),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexWrite(idexWrite), .idexFlush(idexFlush), .exmemWrite(exmemWrite),
    .memwbWrite(memwbWrite), .state(state), .stallCount(stallCount),
    .memTimeout(memTimeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbWrite}
  function automatic logic [6:0] model_ctl();
    logic [6:0] tbl [6];
    bit conds [5];
    bit lu;
    int sel;
    tbl[0] = 7'b0000000;  // memory stall
    tbl[1] = 7'b0111011;  // discarding stale fetch
    tbl[2] = 7'b1111111;  // taken branch
    tbl[3] = 7'b0001111;  // load-use bubble
    tbl[4] = 7'b0111011;  // fetch not ready
    tbl[5] = 7'b1101011;  // clean
    lu = idexMemRead && (int'(idexRd) != 0) &&
         ((idUsesRs1 && idRs1 == idexRd) || (idUsesRs2 && idRs2 == idexRd));
    conds[0] = memReq && !memReady;
    conds[1] = (m_state == 2);
    conds[2] = exBranchTaken;
    conds[3] = lu;
    conds[4] = !ifReady;
    sel = 5;
    for (int i = 4; i >= 0; i--) if (conds[i]) sel = i;
    return tbl[sel];
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_wait = 0; m_to = 1'b0;
  endtask

  // Compare current cycle, then advance model and DUT across one rising edge.
  task automatic step();
    logic [6:0] e;
    bit ms;
    #1;
    e = model_ctl();
    check("ctl", {pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, memwbWrite}, {25'd0, e});
    check("state", {30'd0, state}, m_state);
    check("stallCount", {16'd0, stallCount}, m_stall);
    check("memTimeout", {31'd0, memTimeout}, {31'd0, m_to});
    @(posedge clk);
    ms = memReq && !memReady;
    if (clrCount) m_stall = 0;
    else if (!e[6] && m_stall < 65535) m_stall++;
    m_wait = ms ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    if (m_wait == 255) m_to = 1'b1;
    case (m_state)
      0: if (ms) m_state = 1; else if (exBranchTaken && !ifReady) m_state = 2;
      1: if (memReady) m_state = 0;
      2: if (ifReady) m_state = 0;
      default: m_state = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic idle();
    idRs1 = '0; idRs2 = '0; idexRd = '0;
    idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idexMemRead = 1'b0; exBranchTaken = 1'b0;
    memReq = 1'b0; memReady = 1'b1; ifReady = 1'b1; clrCount = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_stallCount", {16'd0, stallCount}, 32'd0);
    check("rst_memTimeout", {31'd0, memTimeout}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    check("por_state", {30'd0, state}, 32'd0);
    check("por_stallCount", {16'd0, stallCount}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load-use on rs2: one bubble
    idexMemRead = 1'b1; idexRd = 5'(5); idRs2 = 5'(5); idUsesRs2 = 1'b1;
    #1;
    check("lu_pcWrite", {31'd0, pcWrite}, 32'd0);
    check("lu_idexFlush", {31'd0, idexFlush}, 32'd1);
    #(-0); step();
    idle(); step();
    check("lu_stallCount", {16'd0, stallCount}, 32'd1);
    // Destination x0 or rs2 not read: no stall
    idexMemRead = 1'b1; idexRd = '0; idRs2 = '0; idUsesRs2 = 1'b1; step();
    idexRd = 5'(5); idRs2 = 5'(5); idUsesRs2 = 1'b0; step();
    // Load-use and branch together: branch wins
    idUsesRs2 = 1'b1; exBranchTaken = 1'b1; step();
    idle();

    // Three memory stall cycles then ready
    clrCount = 1'b1; step(); clrCount = 1'b0;
    memReq = 1'b1; memReady = 1'b0;
    repeat (3) step();
    check("mw_state", {30'd0, state}, 32'd1);
    memReady = 1'b1; step();
    check("mw_stallCount", {16'd0, stallCount}, 32'd3);
    check("mw_run", {30'd0, state}, 32'd0);
    idle();

    // Branch with fetch pending: DISCARD, released two cycles later
    exBranchTaken = 1'b1; ifReady = 1'b0; step();
    exBranchTaken = 1'b0; step();
    check("disc_state", {30'd0, state}, 32'd2);
    ifReady = 1'b1; step();
    check("disc_exit", {30'd0, state}, 32'd0);

    // Long memory stall: timeout at 255 cycles, sticky, cleared by reset
    memReq = 1'b1; memReady = 1'b0;
    repeat (254) step();
    check("to_before", {31'd0, memTimeout}, 32'd0);
    repeat (46) step();
    check("to_set", {31'd0, memTimeout}, 32'd1);
    memReady = 1'b1; step(); step();
    check("to_sticky", {31'd0, memTimeout}, 32'd1);
    idle();
    async_reset();

    // Reset in the middle of DISCARD and of MEMWAIT
    exBranchTaken = 1'b1; ifReady = 1'b0; step(); idle(); ifReady = 1'b0;
    async_reset(); idle(); step();
    memReq = 1'b1; memReady = 1'b0; step(); step();
    async_reset(); idle(); step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      idRs1 = AW'($urandom_range(0, 3));
      idRs2 = AW'($urandom_range(0, 3));
      idexRd = AW'($urandom_range(0, 3));
      idUsesRs1 = 1'($urandom_range(0, 1));
      idUsesRs2 = 1'($urandom_range(0, 1));
      idexMemRead = 1'($urandom_range(0, 1));
      exBranchTaken = ($urandom_range(0, 3) == 0);
      memReq = 1'($urandom_range(0, 1));
      memReady = ($urandom_range(0, 3) != 0);
      ifReady = ($urandom_range(0, 3) != 0);
      clrCount = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
